hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Register-file hazard controller between the fetch and decode stages of the pipeline.
- Tracks the outstanding writes to each architectural register, counting every issued write until its writeback.
- Stalls issue on read-after-write hazards and on write-count overflow.
- Exposes a flush to squash tracking and a stall-cycle performance counter.

Parameters:
- REGNUM, 16, number of architectural registers tracked.
- ADDRESSWIDTH, 4, register address width.
- MAXOUT, 3, maximum outstanding writes per register; sets the counter width (2 bits).
- PERFWIDTH, 16, stall-counter width.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- issueValid  input  1  decode presents an instruction
- src1Address  input  ADDRESSWIDTH  first source register
- src2Address  input  ADDRESSWIDTH  second source register
- useSrc1  input  1  instruction reads src1
- useSrc2  input  1  instruction reads src2
- obtainPCAsR1  input  1  src1 is the PC; src1 never hazards
- destAddress  input  ADDRESSWIDTH  destination register
- writesDest  input  1  instruction writes destAddress
- wbValid  input  1  register-file writeback this cycle
- wbAddress  input  ADDRESSWIDTH  writeback destination
- flush  input  1  squash all tracking
- stall  output  1  hold fetch/decode; issue not accepted
- issueAccept  output  1  issueValid & !stall & !flush
- fwd1  output  1  src1 forwarded from the current writeback
- fwd2  output  1  src2 forwarded from the current writeback
- underflowError  output  1  sticky: writeback to a register with count 0
- stallCount  output  PERFWIDTH  cycles with stall asserted

Behaviour:
- State: count[REGNUM] (2 bits each), underflowError, stallCount. All are 0 on reset assertion, asynchronously.
- src1Hazard = issueValid & useSrc1 & !obtainPCAsR1 & count[src1Address] != 0.
- src2Hazard = issueValid & useSrc2 & count[src2Address] != 0.
- wawFull = issueValid & writesDest & count[destAddress] == MAXOUT.
- stall (combinational) = src1Hazard | src2Hazard | wawFull, forced 0 while flush = 1. stall is 0 whenever issueValid = 0.
- On a clock edge, per register r:
  - inc = issueAccept & writesDest & destAddress == r.
  - dec = wbValid & wbAddress == r.
  - inc & dec: count unchanged.
  - inc only: count + 1. It never exceeds MAXOUT, because wawFull blocks the issue.
  - dec only, count > 0: count - 1.
  - dec only, count == 0: count stays 0 and underflowError is set. It remains set until reset.
- flush: every count goes to 0 at the next edge, overriding inc and dec. issueAccept is 0 during flush. A writeback in the flush cycle is ignored and raises no error.
- A writeback arriving after a flush to a register whose count is 0 sets underflowError. Upstream must drain or squash those writebacks.
- Source equal to destination in the same instruction: the hazard is checked against the pre-issue count, so there is no self-stall.
- stallCount increments by 1 each cycle stall = 1 and wraps at 2^PERFWIDTH. It is unaffected by flush.
- Latency: stall and issueAccept are same-cycle combinational. A count update is visible the cycle after the edge.
- fwd1 and fwd2 are 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: SCOREBOARD_FORWARD_EN.
- Defined:
  - If wbValid & wbAddress == srcN & count[srcN] == 1 and the same cycle has no accepted issue to srcN, srcN is not a hazard. fwdN = 1 for srcN in use.
  - The datapath then muxes the writeback data into the decode operand.
- Undefined:
  - Those cases stall for one cycle.
  - fwd1 and fwd2 are tied to 0.

Decomposition:
- Package hazard_pkg holds:
  - typedef regaddr_t (ADDRESSWIDTH bits).
  - typedef outcount_t (2 bits).
  - Constant MAXOUT.
  - Constant PERFWIDTH.
- Sub-module scoreboard_entry: one per register, generated REGNUM times.
  - Holds the count.
  - Handles inc, dec and flush.
  - Outputs busy, full, lastOne and an underflow pulse.
- The top level ORs the underflow pulses into the sticky flag and builds the hazard and stall logic.

Test Plan:
- Reset with reset = 0 mid-run, counts nonzero → all counts 0, stall = 0, stallCount = 0, underflowError = 0 immediately.
- Issue dest = 5; next cycle issue src1 = 5 → stall = 1, stallCount increments each stalled cycle. wbValid with wbAddress = 5 → stall drops the following cycle (or the same cycle with fwd1 = 1 under SCOREBOARD_FORWARD_EN).
- Three issues to dest = 3 with no writeback, then a fourth → fourth stalls on wawFull. One writeback to 3 → fourth accepted next cycle, count returns to 3.
- Issue dest = 7 with wbValid, wbAddress = 7 in the same cycle, count = 1 → count stays 1.
- src1 = 2 pending with obtainPCAsR1 = 1 → no stall.
- flush with counts nonzero → counts 0; later writeback to 4 → underflowError = 1, sticky until reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the register-file hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REGNUM       = 16;
  localparam int unsigned ADDRESSWIDTH = 4;
  localparam int unsigned MAXOUT       = 3;
  localparam int unsigned PERFWIDTH    = 16;

  typedef logic [ADDRESSWIDTH-1:0] regaddr_t;
  typedef logic [1:0]              outcount_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One register's outstanding-write counter: increments on accepted issue,
// decrements on writeback, clears on flush, flags writeback-with-nothing-pending.
module scoreboard_entry
  import hazard_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic flush,
  output logic busy,
  output logic full,
  output logic lastOne,
  output logic underflow
);

  outcount_t count_q, count_d;

  // Next count; simultaneous inc and dec cancel, flush wins over both.
  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    if (flush) begin
      count_d = '0;
    end else if (inc && !dec) begin
      count_d = count_q + 2'd1;
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - 2'd1;
      else               underflow = 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  // Status flags decoded from the registered count.
  always_comb begin
    busy    = (count_q != '0);
    full    = (count_q == outcount_t'(MAXOUT));
    lastOne = (count_q == 2'd1);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-file hazard controller between fetch and decode.
// Optional feature macro: SCOREBOARD_FORWARD_EN (writeback-to-decode forwarding
// removes the one-cycle RAW stall when the last pending write retires now).
module hazard_scoreboard #(
  parameter int unsigned REGNUM       = hazard_pkg::REGNUM,
  parameter int unsigned ADDRESSWIDTH = hazard_pkg::ADDRESSWIDTH,
  parameter int unsigned MAXOUT       = hazard_pkg::MAXOUT,
  parameter int unsigned PERFWIDTH    = hazard_pkg::PERFWIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issueValid,
  input  logic [ADDRESSWIDTH-1:0] src1Address,
  input  logic [ADDRESSWIDTH-1:0] src2Address,
  input  logic                    useSrc1,
  input  logic                    useSrc2,
  input  logic                    obtainPCAsR1,
  input  logic [ADDRESSWIDTH-1:0] destAddress,
  input  logic                    writesDest,
  input  logic                    wbValid,
  input  logic [ADDRESSWIDTH-1:0] wbAddress,
  input  logic                    flush,
  output logic                    stall,
  output logic                    issueAccept,
  output logic                    fwd1,
  output logic                    fwd2,
  output logic                    underflowError,
  output logic [PERFWIDTH-1:0]    stallCount
);

  logic [REGNUM-1:0] busy, full, last_one, underflow, inc, dec;
  logic src1_use, src2_use, fwd1_ok, fwd2_ok;
  logic src1_hazard, src2_hazard, waw_full;
  logic underflow_q;
  logic [PERFWIDTH-1:0] stall_count_q;

  for (genvar g = 0; g < REGNUM; g++) begin : g_entry
    assign inc[g] = issueAccept & writesDest & (destAddress == ADDRESSWIDTH'(g));
    assign dec[g] = wbValid & (wbAddress == ADDRESSWIDTH'(g));

    scoreboard_entry u_entry (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc[g]),
      .dec       (dec[g]),
      .flush     (flush),
      .busy      (busy[g]),
      .full      (full[g]),
      .lastOne   (last_one[g]),
      .underflow (underflow[g])
    );
  end

  // Hazard detection and issue handshake, all against pre-issue counts.
  always_comb begin
    src1_use = issueValid & useSrc1 & ~obtainPCAsR1;
    src2_use = issueValid & useSrc2;
`ifdef SCOREBOARD_FORWARD_EN
    // The issue-to-same-register check uses the presented instruction rather
    // than the accept, which would otherwise form a loop through stall.
    fwd1_ok = wbValid & (wbAddress == src1Address) & last_one[src1Address]
            & ~(issueValid & writesDest & (destAddress == src1Address));
    fwd2_ok = wbValid & (wbAddress == src2Address) & last_one[src2Address]
            & ~(issueValid & writesDest & (destAddress == src2Address));
`else
    fwd1_ok = 1'b0;
    fwd2_ok = 1'b0;
`endif
    src1_hazard = src1_use & busy[src1Address] & ~fwd1_ok;
    src2_hazard = src2_use & busy[src2Address] & ~fwd2_ok;
    waw_full    = issueValid & writesDest & full[destAddress];
    stall       = (src1_hazard | src2_hazard | waw_full) & ~flush;
    issueAccept = issueValid & ~stall & ~flush;
    fwd1        = src1_use & fwd1_ok;
    fwd2        = src2_use & fwd2_ok;
  end

  // Sticky underflow flag and free-running stall-cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underflow_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      underflow_q   <= underflow_q | (|underflow);
      stall_count_q <= stall_count_q + PERFWIDTH'(stall);
    end
  end

  assign underflowError = underflow_q;
  assign stallCount     = stall_count_q;

endmodule
